inst_rr_scheduler: RTL



---
 rtl/inst_rr_scheduler.sv | 108 ++++++++++
 1 files changed

// File: rtl/inst_rr_scheduler.sv
// Round-robin owner of a single exclusive resource slot shared by N_REQ instances.
// A grant is held until done at the granted index or until the watchdog revokes it.
module inst_rr_scheduler #(
    parameter int N_REQ   = 15,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout_pulse,
    output logic             timeout_sticky,
    output logic [ID_W-1:0]  timeout_id
);

    // Handshake: a requester holds req until granted; the slot stays owned
    // until done[grant_id] is seen or the watchdog expires, whichever first.
    localparam logic [0:0]       IDLE      = 1'b0;
    localparam logic [0:0]       BUSY      = 1'b1;
    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
    localparam logic [ID_W:0]    N_EXT     = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);

    logic [0:0]      state_q;
    logic [ID_W-1:0] ptr_q;
    logic [15:0]     wdog_q;

    logic            found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   idx;
    logic            done_hit;
    logic            expire;
    logic [ID_W-1:0] next_ptr;

    // Rotating priority search; one extra bit keeps ptr+i from overflowing
    // before it is folded back modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = idx[ID_W-1:0];
            end
        end
    end

    assign done_hit = done[grant_id];
    assign expire   = (wdog_q == WDOG_LAST);
    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            wdog_q         <= '0;
            grant          <= '0;
            grant_id       <= '0;
            busy           <= 1'b0;
            timeout_pulse  <= 1'b0;
            timeout_sticky <= 1'b0;
            timeout_id     <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant    <= ONE_HOT_0 << win_id;
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        wdog_q   <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_hit || expire) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                        ptr_q   <= next_ptr;
                        // done in the expiry cycle is a normal release, not a timeout
                        if (!done_hit) begin
                            timeout_pulse  <= 1'b1;
                            timeout_sticky <= 1'b1;
                            timeout_id     <= grant_id;
                        end
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
